// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI request arbiter: FSM states, default widths and the
// request bundle a requester presents.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } arb_req_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first set req_valid bit at or above
// rr_ptr, wrapping modulo NUM_REQ. Returns one-hot grant and its index.
module axi_rr_picker
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr never exceeds NUM_REQ-1, so one subtraction wraps the sum.
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req_valid[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI master among NUM_REQ
// requesters. Optional response timeout via macro AXI_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; on a grant latch the request and pulse req_ready
// ISSUE | drive a single m_wr_en or m_rd_en pulse
// WAIT  | wait for the matching completion (or timeout when enabled)
// RESP  | rsp_valid pulse to the granted requester with rdata/err
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = 15
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        m_wr_en,
  output logic                        m_rd_en,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  input  logic                        m_b_valid,
  input  logic                        m_b_response,
  input  logic                        m_rd_valid,
  input  logic [DATA_W-1:0]           m_rdata
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               cur_we;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               done;

  axi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Only the completion matching the issued direction counts.
  assign done = cur_we ? m_b_valid : m_rd_valid;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_oh    <= '0;
      cur_we    <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_wr_en   <= 1'b0;
      m_rd_en   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      m_wr_en   <= 1'b0;
      m_rd_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            req_ready <= pick_oh;
            gnt_oh    <= pick_oh;
            cur_we    <= req_we[pick_idx];
            m_addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            m_wdata   <= req_wdata[pick_idx*DATA_W +: DATA_W];
            rr_ptr    <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m_wr_en <= cur_we;
          m_rd_en <= ~cur_we;
`ifdef AXI_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= WAIT;
        end
        WAIT: begin
          if (done) begin
            rsp_valid <= gnt_oh;
            rsp_err   <= cur_we & m_b_response;
            rsp_rdata <= cur_we ? '0 : m_rdata;
            state     <= RESP;
          end
`ifdef AXI_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            rsp_valid <= gnt_oh;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter (NUM_REQ=2): write, read, error, contention,
// reset mid-WAIT and the response timeout (both builds of AXI_ARB_TIMEOUT_EN).
module tb_axi_req_arbiter;
  import axi_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = ADDR_W_DEF;
  localparam int DATA_W  = DATA_W_DEF;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      m_wr_en;
  logic                      m_rd_en;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_b_valid;
  logic                      m_b_response;
  logic                      m_rd_valid;
  logic [DATA_W-1:0]         m_rdata;

  int checks = 0;
  int errors = 0;
  int bad;

  always #5 clk = ~clk;

  axi_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TMO_CYC (15)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .m_wr_en      (m_wr_en),
    .m_rd_en      (m_rd_en),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_b_valid    (m_b_valid),
    .m_b_response (m_b_response),
    .m_rd_valid   (m_rd_valid),
    .m_rdata      (m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rdata"}, 32'(rsp_rdata), 0);
    check({tag, "_err"}, 32'(rsp_err), 0);
    check({tag, "_en"}, 32'({m_wr_en, m_rd_en}), 0);
    check({tag, "_addr"}, 32'(m_addr), 0);
    check({tag, "_wdata"}, 32'(m_wdata), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic arb_req_t mk(input logic we, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d);
    arb_req_t r;
    r.we    = we;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  task automatic set_req(input arb_req_t r0, input arb_req_t r1);
    req_we    = {r1.we, r0.we};
    req_addr  = {r1.addr, r0.addr};
    req_wdata = {r1.wdata, r0.wdata};
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    set_req(mk(1'b0, 3'h0, 4'h0), mk(1'b0, 3'h0, 4'h0));
    m_b_valid    = 1'b0;
    m_b_response = 1'b0;
    m_rd_valid   = 1'b0;
    m_rdata      = '0;
    #2;
    check_zero("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    // single write from req0
    req_valid = 2'b01;
    set_req(mk(1'b1, 3'h5, 4'hA), mk(1'b0, 3'h0, 4'h0));
    step();
    check("w_ready", 32'(req_ready), 2'b01);
    check("w_addr", 32'(m_addr), 3'h5);
    check("w_wdata", 32'(m_wdata), 4'hA);
    check("w_en_early", 32'({m_wr_en, m_rd_en}), 0);
    req_valid = 2'b00;
    step();
    check("w_en", 32'({m_wr_en, m_rd_en}), 2'b10);
    check("w_ready_clr", 32'(req_ready), 0);
    step();
    check("w_en_once", 32'({m_wr_en, m_rd_en}), 0);
    step();
    check("w_rsp_early", 32'(rsp_valid), 0);
    m_b_valid = 1'b1;
    m_b_response = 1'b0;
    step();
    m_b_valid = 1'b0;
    check("w_rsp", 32'(rsp_valid), 2'b01);
    check("w_err", 32'(rsp_err), 0);
    check("w_addr_hold", 32'(m_addr), 3'h5);
    step();
    check("w_rsp_once", 32'(rsp_valid), 0);

    // single read from req1; completion during ISSUE must be ignored
    req_valid = 2'b10;
    set_req(mk(1'b0, 3'h0, 4'h0), mk(1'b0, 3'h2, 4'h0));
    step();
    check("r_ready", 32'(req_ready), 2'b10);
    req_valid  = 2'b00;
    m_rd_valid = 1'b1;
    m_rdata    = 4'hE;
    step();
    m_rd_valid = 1'b0;
    check("r_en", 32'({m_wr_en, m_rd_en}), 2'b01);
    check("r_addr", 32'(m_addr), 3'h2);
    check("r_issue_ignored", 32'(rsp_valid), 0);
    step();
    check("r_quiet1", 32'(rsp_valid), 0);
    step();
    check("r_quiet2", 32'(rsp_valid), 0);
    step();
    m_rd_valid = 1'b1;
    m_rdata    = 4'h7;
    step();
    m_rd_valid = 1'b0;
    check("r_rsp", 32'(rsp_valid), 2'b10);
    check("r_rdata", 32'(rsp_rdata), 4'h7);
    check("r_err", 32'(rsp_err), 0);
    step();
    check("r_rsp_once", 32'(rsp_valid), 0);
    check("r_rdata_hold", 32'(rsp_rdata), 4'h7);

    // write error from req1 with a spurious read completion in WAIT
    req_valid = 2'b10;
    set_req(mk(1'b0, 3'h0, 4'h0), mk(1'b1, 3'h4, 4'h9));
    step();
    check("e_ready", 32'(req_ready), 2'b10);
    req_valid = 2'b00;
    step();
    check("e_en", 32'({m_wr_en, m_rd_en}), 2'b10);
    check("e_wdata", 32'(m_wdata), 4'h9);
    m_rd_valid = 1'b1;
    m_rdata    = 4'hF;
    step();
    m_rd_valid = 1'b0;
    check("e_spurious", 32'(rsp_valid), 0);
    m_b_valid    = 1'b1;
    m_b_response = 1'b1;
    step();
    m_b_valid    = 1'b0;
    m_b_response = 1'b0;
    check("e_rsp", 32'(rsp_valid), 2'b10);
    check("e_err", 32'(rsp_err), 1);
    check("e_rdata", 32'(rsp_rdata), 0);
    step();
    check("e_rsp_once", 32'(rsp_valid), 0);

    // contention: both held valid, grants alternate 0,1,0,1
    req_valid = 2'b11;
    set_req(mk(1'b1, 3'h6, 4'h3), mk(1'b0, 3'h1, 4'hC));
    for (int t = 0; t < 4; t++) begin
      int g;
      logic [1:0] oh;
      g  = t % 2;
      oh = (g == 1) ? 2'b10 : 2'b01;
      step();
      check("c_ready", 32'(req_ready), 32'(oh));
      check("c_addr", 32'(m_addr), (g == 1) ? 3'h1 : 3'h6);
      step();
      check("c_en", 32'({m_wr_en, m_rd_en}), (g == 1) ? 2'b01 : 2'b10);
      step();
      check("c_en_once", 32'({m_wr_en, m_rd_en}), 0);
      if (g == 1) begin
        m_rd_valid = 1'b1;
        m_rdata    = (t == 1) ? 4'h5 : 4'h6;
      end else begin
        m_b_valid = 1'b1;
      end
      step();
      m_rd_valid = 1'b0;
      m_b_valid  = 1'b0;
      check("c_rsp", 32'(rsp_valid), 32'(oh));
      if (g == 1) check("c_rdata", 32'(rsp_rdata), (t == 1) ? 4'h5 : 4'h6);
      else        check("c_err", 32'(rsp_err), 0);
      if (t == 3) req_valid = 2'b00;
      step();
      check("c_rsp_once", 32'(rsp_valid), 0);
    end

    // reset mid-WAIT after granting req0 (rr_ptr moves to 1)
    req_valid = 2'b01;
    set_req(mk(1'b1, 3'h7, 4'h5), mk(1'b0, 3'h3, 4'h0));
    step();
    check("x_ready", 32'(req_ready), 2'b01);
    req_valid = 2'b00;
    step();
    check("x_en", 32'({m_wr_en, m_rd_en}), 2'b10);
    reset_n   = 1'b0;
    m_b_valid = 1'b1;
    #1;
    check_zero("x_rst");
    step();
    reset_n   = 1'b1;
    m_b_valid = 1'b0;
    check("x_no_rsp", 32'(rsp_valid), 0);
    req_valid = 2'b11;
    set_req(mk(1'b0, 3'h7, 4'h0), mk(1'b0, 3'h3, 4'h0));
    step();
    check("x_first_grant", 32'(req_ready), 2'b01);
    check("x_addr", 32'(m_addr), 3'h7);
    req_valid = 2'b00;
    step();
    check("x_en2", 32'({m_wr_en, m_rd_en}), 2'b01);
    step();
    m_rd_valid = 1'b1;
    m_rdata    = 4'hB;
    step();
    m_rd_valid = 1'b0;
    check("x_rsp", 32'(rsp_valid), 2'b01);
    check("x_rdata", 32'(rsp_rdata), 4'hB);
    step();

    // read from req0 that never completes
    req_valid = 2'b01;
    set_req(mk(1'b0, 3'h3, 4'h0), mk(1'b0, 3'h0, 4'h0));
    step();
    check("t_ready", 32'(req_ready), 2'b01);
    req_valid = 2'b00;
    step();
    check("t_en", 32'({m_wr_en, m_rd_en}), 2'b01);
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (rsp_valid != '0) bad++;
    end
    check("t_wait_quiet", 32'(bad), 0);
`ifdef AXI_ARB_TIMEOUT_EN
    step();
    check("t_rsp", 32'(rsp_valid), 2'b01);
    check("t_err", 32'(rsp_err), 1);
    check("t_rdata", 32'(rsp_rdata), 0);
    step();
    check("t_rsp_once", 32'(rsp_valid), 0);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rsp_valid != '0 || m_rd_en || m_wr_en) bad++;
    end
    check("t_no_rsp", 32'(bad), 0);
    check("t_rdata_hold", 32'(rsp_rdata), 4'hB);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
